vert_cmd_link: RTL and testbench
================================

VERT_CMD_LINK -- requirements
Module: vert_cmd_link

Interface
REQ-001 SHALL have parameter STALE_LIMIT, default 2500000, max cycles between committed status packs before commands are blocked.
REQ-002 SHALL have port CLK_SE_AR, in, 1, sole clock, rising edge.
REQ-003 SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_motor in 4, cmd_divider in 15, cmd_steps in 15, cmd_dir in 1: motor command, valid/ready handshake.
REQ-005 SHALL have port cmd_reject, out, 1, one-cycle pulse when an accepted command is dropped.
REQ-006 SHALL have ports TxD_start out 1, TxD_data out 8, TxD_busy in 1, connecting to the byte UART transmitter.
REQ-007 SHALL have ports RxD_data_ready in 1, RxD_data in 8, connecting to the byte UART receiver.
REQ-008 SHALL have ports motor_pending out 10, term_flags out 10, status_valid out 1 (commit pulse), status_stale out 1, link_err out 1 (pulse).

Function
REQ-009 SHALL accept a command only when cmd_valid && cmd_ready; cmd_ready = TX FSM in IDLE && !status_stale.
REQ-010 SHALL on accept pulse cmd_reject, send nothing, if cmd_motor>9, motor_pending[m]=1 or blocked[m]=1.
REQ-011 SHALL otherwise build W[39:0] = {5'b0, dir, steps[14:0], divider[14:0], motor[3:0]} and send 5 bytes LSB first (byte k = W[8k+7:8k]).
REQ-012 SHALL implement TX FSM IDLE -> START -> SKIP -> WAITB -> (START for next byte | DONE) -> IDLE.
REQ-013 START: TxD_start=1 for exactly one cycle with TxD_data valid; first START is the cycle after accept; SKIP ignores TxD_busy for one cycle; WAITB holds until TxD_busy=0.
REQ-014 DONE SHALL set blocked[m]; byte-to-byte gap is the minimum the FSM allows (no extra delay).
REQ-015 SHALL detect received bytes on the rising edge of RxD_data_ready (registered previous value); one byte per edge.
REQ-016 Status byte format: tag=[7:6], bit5 must be 0, data=[4:0]; a pack is tags 0,1,2,3 in order.
REQ-017 Tag 0 SHALL always restart assembly and snapshot blocked_seen <= blocked.
REQ-018 Out-of-order tag or bit5=1 SHALL discard the partial pack, pulse link_err, and leave the committed outputs unchanged.
REQ-019 Tag 3 completing a valid sequence SHALL commit on the next edge: motor_pending={d1,d0}, term_flags={d3,d2}, status_valid=1 for one cycle, blocked <= blocked & ~blocked_seen.
REQ-020 On a simultaneous commit and DONE, the newly set blocked bit SHALL survive.
REQ-021 SHALL use a stale counter reloaded to STALE_LIMIT on each commit and decremented otherwise; at 0, status_stale=1 until the next commit.
REQ-022 Status_stale rising mid-frame SHALL NOT abort the frame in progress.

Reset
REQ-023 rst_n=0 SHALL asynchronously force: FSM IDLE, TxD_start=0, TxD_data=0, cmd_reject=0, motor_pending=0, term_flags=0, blocked=0, blocked_seen=0, status_valid=0, link_err=0, status_stale=1, RX assembly empty.
REQ-024 Reset during a frame SHALL abandon it; no partial frame resumes after release.

Structure
REQ-025 Shared package SHALL hold: frame length 5, field offsets (motor 0, divider 4, steps 19, dir 34), status tag values 0..3, motor count 10.
REQ-026 Status decoding (REQ-015..019) SHALL be one sub-module, vert_status_rx; TX FSM and gating stay in vert_cmd_link.

Verification
REQ-027 Status bytes 0x05,0x40,0x83,0xC1 -> status_valid pulse, motor_pending=0x005, term_flags=0x023, status_stale=0.
REQ-028 After all-zero pack, cmd motor=3, divider=0x00FF, steps=6, dir=1 -> TxD bytes 0xF3,0x0F,0x30,0x00,0x04; each TxD_start is a single cycle; blocked[3]=1.
REQ-029 Repeat motor 3 before a new pack -> cmd_reject pulse, no TxD_start. Tag-0 byte arriving before DONE, then pack completing -> blocked[3] still 1. Next full pack -> blocked[3]=0.
REQ-030 Bytes 0x00,0x80 -> link_err pulse, outputs unchanged. Also cmd_motor=12 -> cmd_reject, no TxD_start.
REQ-031 STALE_LIMIT=100 with no RX -> status_stale=1 at cycle 100 and cmd_ready=0. Valid pack -> cmd_ready=1.
REQ-032 rst_n low during byte 2 -> TxD_start=0, status_stale=1 immediately. After release, no further bytes are sent.

Source files
------------

// File: rtl/vert_cmd_link_pkg.sv
// Shared constants, command word layout and TX state encoding for the vertical-axis command link.
package vert_cmd_link_pkg;

  localparam int FRAME_LEN   = 5;
  localparam int WORD_W      = 8 * FRAME_LEN;
  localparam int MOTOR_COUNT = 10;

  localparam int OFF_MOTOR   = 0;
  localparam int OFF_DIVIDER = 4;
  localparam int OFF_STEPS   = 19;
  localparam int OFF_DIR     = 34;

  localparam logic [1:0] TAG_D0 = 2'd0;
  localparam logic [1:0] TAG_D1 = 2'd1;
  localparam logic [1:0] TAG_D2 = 2'd2;
  localparam logic [1:0] TAG_D3 = 2'd3;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_SKIP  = 3'd2,
    TX_WAITB = 3'd3,
    TX_DONE  = 3'd4
  } tx_state_t;

  function automatic logic [WORD_W-1:0] pack_cmd(input logic [3:0] motor,
                                                 input logic [14:0] divider,
                                                 input logic [14:0] steps,
                                                 input logic dir);
    logic [WORD_W-1:0] w;
    w = '0;
    w[OFF_MOTOR +: 4]    = motor;
    w[OFF_DIVIDER +: 15] = divider;
    w[OFF_STEPS +: 15]   = steps;
    w[OFF_DIR]           = dir;
    return w;
  endfunction

endpackage

// File: rtl/vert_cmd_link_status_rx.sv
// Status pack decoder: assembles tagged bytes 0..3 into committed motor/terminal flags
// and runs the staleness countdown that gates new commands.
module vert_status_rx
  import vert_cmd_link_pkg::*;
#(
  parameter int unsigned STALE_LIMIT = 2500000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_ready,
  input  logic [7:0]             rx_data,
  input  logic [MOTOR_COUNT-1:0] blocked,
  output logic [MOTOR_COUNT-1:0] blocked_seen,
  output logic                   commit,
  output logic [9:0]             motor_pending,
  output logic [9:0]             term_flags,
  output logic                   status_valid,
  output logic                   status_stale,
  output logic                   link_err
);

  logic        rdy_q;
  logic        byte_evt;
  logic        active;
  logic [1:0]  exp_tag;
  logic [4:0]  d0, d1, d2;
  logic [31:0] stale_cnt;
  logic [1:0]  tag;
  logic        bit5;
  logic [4:0]  data;
  logic        seq_ok;

  assign tag      = rx_data[7:6];
  assign bit5     = rx_data[5];
  assign data     = rx_data[4:0];
  assign byte_evt = rx_ready & ~rdy_q;
  assign seq_ok   = active && (tag == exp_tag);
  assign commit   = byte_evt && !bit5 && (tag == TAG_D3) && seq_ok;
  assign status_stale = (stale_cnt == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q         <= 1'b0;
      active        <= 1'b0;
      exp_tag       <= TAG_D0;
      d0            <= '0;
      d1            <= '0;
      d2            <= '0;
      blocked_seen  <= '0;
      motor_pending <= '0;
      term_flags    <= '0;
      status_valid  <= 1'b0;
      link_err      <= 1'b0;
      stale_cnt     <= 32'd0;
    end else begin
      rdy_q        <= rx_ready;
      status_valid <= commit;
      link_err     <= 1'b0;
      if (byte_evt) begin
        if (bit5) begin
          active   <= 1'b0;
          link_err <= 1'b1;
        end else if (tag == TAG_D0) begin
          // Tag 0 always starts over, even in the middle of a pack.
          active       <= 1'b1;
          exp_tag      <= TAG_D1;
          d0           <= data;
          blocked_seen <= blocked;
        end else if (seq_ok) begin
          if (tag == TAG_D1) d1 <= data;
          if (tag == TAG_D2) d2 <= data;
          if (tag == TAG_D3) active <= 1'b0;
          else exp_tag <= exp_tag + 2'd1;
        end else begin
          active   <= 1'b0;
          link_err <= 1'b1;
        end
      end
      if (commit) begin
        motor_pending <= {d1, d0};
        term_flags    <= {data, d2};
        stale_cnt     <= 32'(STALE_LIMIT);
      end else if (stale_cnt != 32'd0) begin
        stale_cnt <= stale_cnt - 32'd1;
      end
    end
  end

endmodule

// File: rtl/vert_cmd_link.sv
// Motor command link: gates commands on fresh status, frames accepted commands into five
// UART bytes, and tracks which motors have a command in flight (blocked) until status clears them.
module vert_cmd_link
  import vert_cmd_link_pkg::*;
#(
  parameter int unsigned STALE_LIMIT = 2500000
) (
  input  logic        CLK_SE_AR,
  input  logic        rst_n,
  // cmd_* handshake: a command is taken on any rising edge where cmd_valid && cmd_ready.
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_motor,
  input  logic [14:0] cmd_divider,
  input  logic [14:0] cmd_steps,
  input  logic        cmd_dir,
  output logic        cmd_reject,
  output logic        TxD_start,
  output logic [7:0]  TxD_data,
  input  logic        TxD_busy,
  input  logic        RxD_data_ready,
  input  logic [7:0]  RxD_data,
  output logic [9:0]  motor_pending,
  output logic [9:0]  term_flags,
  output logic        status_valid,
  output logic        status_stale,
  output logic        link_err,
  output tx_state_t   tx_state
);

  tx_state_t               state, next_state;
  logic [WORD_W-1:0]       word;
  logic [2:0]              byte_idx;
  logic [3:0]              cur_motor;
  logic [MOTOR_COUNT-1:0]  blocked;
  logic [MOTOR_COUNT-1:0]  blocked_seen;
  logic [MOTOR_COUNT-1:0]  done_bit;
  logic                    commit;
  logic                    accept;
  logic                    cmd_bad;
  logic                    tx_done;
  logic [15:0]             motor_busy;

  vert_status_rx #(.STALE_LIMIT(STALE_LIMIT)) u_rx (
    .clk           (CLK_SE_AR),
    .rst_n         (rst_n),
    .rx_ready      (RxD_data_ready),
    .rx_data       (RxD_data),
    .blocked       (blocked),
    .blocked_seen  (blocked_seen),
    .commit        (commit),
    .motor_pending (motor_pending),
    .term_flags    (term_flags),
    .status_valid  (status_valid),
    .status_stale  (status_stale),
    .link_err      (link_err)
  );

  // Pad to 16 so an out-of-range motor index still selects a defined bit.
  assign motor_busy = {6'b0, motor_pending | blocked};
  assign cmd_bad    = (cmd_motor > 4'(MOTOR_COUNT - 1)) || motor_busy[cmd_motor];
  assign accept     = cmd_valid && cmd_ready;
  assign done_bit   = 10'(1) << cur_motor;
  assign TxD_data   = word[7:0];
  assign tx_state   = state;

  always_ff @(posedge CLK_SE_AR or negedge rst_n) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      TX_IDLE:  if (accept && !cmd_bad) next_state = TX_START;
      TX_START: next_state = TX_SKIP;
      TX_SKIP:  next_state = TX_WAITB;
      TX_WAITB: if (!TxD_busy) next_state = (byte_idx == 3'(FRAME_LEN - 1)) ? TX_DONE : TX_START;
      TX_DONE:  next_state = TX_IDLE;
      default:  next_state = TX_IDLE;
    endcase
  end

  always_comb begin
    TxD_start = (state == TX_START);
    cmd_ready = (state == TX_IDLE) && !status_stale;
    tx_done   = (state == TX_DONE);
  end

  always_ff @(posedge CLK_SE_AR or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      byte_idx   <= '0;
      cur_motor  <= '0;
      cmd_reject <= 1'b0;
      blocked    <= '0;
    end else begin
      cmd_reject <= accept && cmd_bad;
      if (state == TX_IDLE && accept && !cmd_bad) begin
        word      <= pack_cmd(cmd_motor, cmd_divider, cmd_steps, cmd_dir);
        byte_idx  <= '0;
        cur_motor <= cmd_motor;
      end else if (state == TX_WAITB && !TxD_busy) begin
        word     <= word >> 8;
        byte_idx <= byte_idx + 3'd1;
      end
      // Clear only what status has seen since its tag 0; a DONE on the same edge still lands.
      blocked <= (blocked & ~(commit ? blocked_seen : '0)) | (tx_done ? done_bit : '0);
    end
  end

endmodule

// File: tb/tb_vert_cmd_link.sv
// Directed bench for vert_cmd_link: status pack table, command table, and hand sequences for
// commit/DONE overlap, staleness timing and reset mid-frame.
module tb_vert_cmd_link;
  import vert_cmd_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_dir, cmd_reject;
  logic [3:0]  cmd_motor;
  logic [14:0] cmd_divider, cmd_steps;
  logic        TxD_start, TxD_busy;
  logic [7:0]  TxD_data;
  logic        RxD_data_ready;
  logic [7:0]  RxD_data;
  logic [9:0]  motor_pending, term_flags;
  logic        status_valid, status_stale, link_err;
  tx_state_t   tx_state;

  always #5 clk = ~clk;

  vert_cmd_link #(.STALE_LIMIT(100)) dut (
    .CLK_SE_AR(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_motor(cmd_motor),
    .cmd_divider(cmd_divider), .cmd_steps(cmd_steps), .cmd_dir(cmd_dir),
    .cmd_reject(cmd_reject),
    .TxD_start(TxD_start), .TxD_data(TxD_data), .TxD_busy(TxD_busy),
    .RxD_data_ready(RxD_data_ready), .RxD_data(RxD_data),
    .motor_pending(motor_pending), .term_flags(term_flags),
    .status_valid(status_valid), .status_stale(status_stale), .link_err(link_err),
    .tx_state(tx_state)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  int vld_cnt = 0, err_cnt = 0, rej_cnt = 0, start_dbl = 0, busy_cnt = 0;
  bit prev_start = 1'b0;

  localparam logic [31:0] PACK_ZERO = 32'hC0_80_40_00;
  localparam logic [31:0] PACK_05   = 32'hC1_83_40_05;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART model: capture each start, hold busy for three cycles, count status pulses.
  initial begin
    TxD_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (TxD_start) begin
        tx_q.push_back(TxD_data);
        if (prev_start) start_dbl++;
        TxD_busy = 1'b1;
        busy_cnt = 3;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) TxD_busy = 1'b0;
      end
      prev_start = TxD_start;
      if (status_valid) vld_cnt++;
      if (link_err) err_cnt++;
      if (cmd_reject) rej_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    RxD_data = b;
    RxD_data_ready = 1'b1;
    @(negedge clk);
    RxD_data_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_pack(input logic [31:0] p);
    for (int k = 0; k < 4; k++) send_byte(p[8*k +: 8]);
  endtask

  task automatic issue_cmd(input logic [3:0] m, input logic [14:0] d, input logic [14:0] s,
                           input logic dir);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", (n < 200), 1);
    cmd_motor = m; cmd_divider = d; cmd_steps = s; cmd_dir = dir;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (tx_state != TX_IDLE && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", (n < 100), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_cmd(input logic [3:0] m, input logic [14:0] d, input logic [14:0] s,
                        input logic dir);
    issue_cmd(m, d, s, dir);
    wait_idle();
  endtask

  task automatic check_frame(input string name, input logic [39:0] w);
    logic [7:0] act;
    exp_q.delete();
    for (int k = 0; k < 5; k++) exp_q.push_back(w[8*k +: 8]);
    check({name, "_len"}, tx_q.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (tx_q.size() > 0) begin
        act = tx_q.pop_front();
        check($sformatf("%s_byte%0d", name, k), act, exp_q.pop_front());
      end
    end
  endtask

  typedef struct {
    int          n;
    logic [47:0] bytes;
    bit          v;
    bit          e;
    logic [9:0]  p;
    logic [9:0]  f;
  } rx_vec_t;

  typedef struct {
    int          pre;
    logic [3:0]  m;
    logic [14:0] d;
    logic [14:0] s;
    logic        dir;
    bit          rej;
    logic [39:0] w;
  } cmd_vec_t;

  rx_vec_t  rv[7];
  cmd_vec_t cv[6];

  initial begin
    int v0, e0, r0, n, n0;

    rv[0] = '{4, 48'h0000_C1_83_40_05, 1, 0, 10'h005, 10'h023};
    rv[1] = '{4, 48'h0000_DF_9F_5F_1F, 1, 0, 10'h3FF, 10'h3FF};
    rv[2] = '{2, 48'h0000_0000_80_00, 0, 1, 10'h3FF, 10'h3FF};
    rv[3] = '{1, 48'h0000_0000_00_20, 0, 1, 10'h3FF, 10'h3FF};
    rv[4] = '{1, 48'h0000_0000_00_C0, 0, 1, 10'h3FF, 10'h3FF};
    rv[5] = '{6, 48'hC1_83_40_05_40_00, 1, 0, 10'h005, 10'h023};
    rv[6] = '{4, 48'h0000_C0_80_40_00, 1, 0, 10'h000, 10'h000};

    cv[0] = '{1, 4'd3,  15'h00FF, 15'd6,    1'b1, 0, 40'h04_0030_0FF3};
    cv[1] = '{0, 4'd3,  15'h00FF, 15'd6,    1'b1, 1, 40'h0};
    cv[2] = '{0, 4'd12, 15'h0001, 15'd1,    1'b0, 1, 40'h0};
    cv[3] = '{1, 4'd9,  15'h7FFF, 15'h7FFF, 1'b0, 0, 40'h03_FFFF_FFF9};
    cv[4] = '{2, 4'd2,  15'h0005, 15'd5,    1'b0, 1, 40'h0};
    cv[5] = '{0, 4'd1,  15'h0001, 15'd1,    1'b0, 0, 40'h00_0008_0011};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_motor = '0; cmd_divider = '0; cmd_steps = '0; cmd_dir = 1'b0;
    RxD_data_ready = 1'b0; RxD_data = '0;
    repeat (3) @(negedge clk);
    check("rst_txd_start", TxD_start, 0);
    check("rst_txd_data", TxD_data, 0);
    check("rst_cmd_reject", cmd_reject, 0);
    check("rst_pending", motor_pending, 0);
    check("rst_flags", term_flags, 0);
    check("rst_status_valid", status_valid, 0);
    check("rst_link_err", link_err, 0);
    check("rst_stale", status_stale, 1);
    check("rst_state", tx_state, TX_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("stale_blocks_ready", cmd_ready, 0);

    for (int i = 0; i < 7; i++) begin
      v0 = vld_cnt; e0 = err_cnt;
      for (int k = 0; k < rv[i].n; k++) send_byte(rv[i].bytes[8*k +: 8]);
      @(negedge clk);
      check($sformatf("rx%0d_valid_pulses", i), vld_cnt - v0, rv[i].v);
      check($sformatf("rx%0d_err_pulses", i), err_cnt - e0, rv[i].e);
      check($sformatf("rx%0d_pending", i), motor_pending, rv[i].p);
      check($sformatf("rx%0d_flags", i), term_flags, rv[i].f);
      check($sformatf("rx%0d_stale", i), status_stale, 0);
    end

    for (int i = 0; i < 6; i++) begin
      if (cv[i].pre == 1) send_pack(PACK_ZERO);
      else if (cv[i].pre == 2) send_pack(PACK_05);
      tx_q.delete();
      r0 = rej_cnt;
      do_cmd(cv[i].m, cv[i].d, cv[i].s, cv[i].dir);
      check($sformatf("cmd%0d_reject", i), rej_cnt - r0, cv[i].rej);
      if (cv[i].rej) check($sformatf("cmd%0d_no_bytes", i), tx_q.size(), 0);
      else check_frame($sformatf("cmd%0d", i), cv[i].w);
    end

    // Tag 0 before DONE, tag 3 committing on the same edge as DONE: blocked[3] must stay set.
    send_pack(PACK_ZERO);
    tx_q.delete();
    issue_cmd(4'd3, 15'h00FF, 15'd6, 1'b1);
    n = 0;
    while (tx_q.size() < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s1_first_start", (n < 100), 1);
    send_byte(8'h00); send_byte(8'h40); send_byte(8'h80);
    n = 0;
    while (tx_state != TX_DONE && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s1_done_seen", (n < 100), 1);
    v0 = vld_cnt;
    RxD_data = 8'hC0;
    RxD_data_ready = 1'b1;
    @(negedge clk);
    RxD_data_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("s1_commit", vld_cnt - v0, 1);
    check_frame("s1", 40'h04_0030_0FF3);
    r0 = rej_cnt;
    do_cmd(4'd3, 15'h00FF, 15'd6, 1'b1);
    check("s1_still_blocked", rej_cnt - r0, 1);
    check("s1_no_bytes", tx_q.size(), 0);
    send_pack(PACK_ZERO);
    r0 = rej_cnt;
    do_cmd(4'd3, 15'h00FF, 15'd6, 1'b1);
    check("s1_unblocked", rej_cnt - r0, 0);
    check_frame("s1_resend", 40'h04_0030_0FF3);

    // Staleness countdown from a commit.
    send_byte(8'h00); send_byte(8'h40); send_byte(8'h80);
    @(negedge clk);
    RxD_data = 8'hC0;
    RxD_data_ready = 1'b1;
    @(negedge clk);
    RxD_data_ready = 1'b0;
    repeat (99) @(negedge clk);
    check("stale_at_99", status_stale, 0);
    @(negedge clk);
    check("stale_at_100", status_stale, 1);
    check("stale_ready_low", cmd_ready, 0);
    send_pack(PACK_ZERO);
    check("fresh_ready_high", cmd_ready, 1);
    check("fresh_not_stale", status_stale, 0);

    // Staleness arriving mid-frame must not cut the frame short.
    repeat (85) @(negedge clk);
    tx_q.delete();
    do_cmd(4'd4, 15'd3, 15'd3, 1'b1);
    check_frame("midstale", 40'h04_0018_0034);
    check("midstale_stale_now", status_stale, 1);

    // Reset during the second byte abandons the frame.
    send_pack(PACK_ZERO);
    tx_q.delete();
    issue_cmd(4'd5, 15'd2, 15'd2, 1'b0);
    n = 0;
    while (tx_q.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_byte2_seen", (n < 100), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_txd_start", TxD_start, 0);
    check("rst_mid_stale", status_stale, 1);
    check("rst_mid_state", tx_state, TX_IDLE);
    check("rst_mid_txd_data", TxD_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = tx_q.size();
    repeat (40) @(negedge clk);
    check("rst_mid_no_more_bytes", tx_q.size(), n0);
    check("rst_mid_ready_low", cmd_ready, 0);

    check("start_single_cycle", start_dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
